// File: rtl/pwm_compare.sv
// pwm_compare: four-channel double-buffered PWM compare stage.
// Optional period status/interrupt enabled by defining PWM_PERIOD_IRQ_EN.
module pwm_compare #(
    parameter int WIDTH    = 8,
    parameter int CHANNELS = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             enable,
    input  logic [WIDTH-1:0] counter_value,
    input  logic [3:0]       polarity,
    input  logic             cfg_write,
    input  logic [1:0]       cfg_channel,
    input  logic [WIDTH-1:0] cfg_compare,
    input  logic [4:0]       irq_enable,
    input  logic [4:0]       irq_clear,
    output logic [3:0]       pwm_out,
    output logic [4:0]       status,
    output logic             irq
);

    logic [WIDTH-1:0]    shadow [CHANNELS];
    logic [WIDTH-1:0]    active [CHANNELS];
    logic [WIDTH-1:0]    eff    [CHANNELS];
    logic [CHANNELS-1:0] pending;
    logic [CHANNELS-1:0] ch_status;
    logic [CHANNELS-1:0] match;
    logic [WIDTH-1:0]    last_value;
    logic                period_status;
    logic                wrap;
    logic                advance;

    assign wrap    = enable && (counter_value < last_value);
    assign advance = (counter_value != last_value);

    // Track the previous count so wraps and halts can be detected.
    always_ff @(posedge clk) begin
        if (rst) last_value <= '0;
        else     last_value <= counter_value;
    end

    // Effective compare: a pending shadow is used already on its wrap cycle.
    always_comb begin
        match = '0;
        for (int i = 0; i < CHANNELS; i++) begin
            eff[i]   = (wrap && pending[i]) ? shadow[i] : active[i];
            match[i] = enable && advance && (counter_value == eff[i]);
        end
    end

    // Shadow/active double buffer with wrap-time transfer.
    always_ff @(posedge clk) begin
        if (rst) begin
            pending <= '0;
            for (int i = 0; i < CHANNELS; i++) begin
                shadow[i] <= '0;
                active[i] <= '0;
            end
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (cfg_write && (cfg_channel == 2'(i))) begin
                    shadow[i] <= cfg_compare;
                    if (enable) begin
                        pending[i] <= 1'b1;
                    end else begin
                        active[i]  <= cfg_compare;
                        pending[i] <= 1'b0;
                    end
                end else if (wrap && pending[i]) begin
                    active[i]  <= shadow[i];
                    pending[i] <= 1'b0;
                end
            end
        end
    end

    // Registered outputs; disabled channels sit at their inactive level.
    always_ff @(posedge clk) begin
        if (rst) begin
            pwm_out <= '0;
        end else begin
            for (int i = 0; i < CHANNELS; i++) begin
                if (enable)
                    pwm_out[i] <= (counter_value < eff[i]) ^ polarity[i];
                else
                    pwm_out[i] <= polarity[i];
            end
        end
    end

    // Sticky match status; a set in the same cycle as a clear wins.
    always_ff @(posedge clk) begin
        if (rst) ch_status <= '0;
        else     ch_status <= (ch_status & ~irq_clear[3:0]) | match;
    end

`ifdef PWM_PERIOD_IRQ_EN
    // Sticky period status, set on every wrap cycle.
    always_ff @(posedge clk) begin
        if (rst)
            period_status <= 1'b0;
        else
            period_status <= (period_status & ~irq_clear[4]) | wrap;
    end
`else
    logic unused_period_clear;
    assign unused_period_clear = irq_clear[4];
    assign period_status = 1'b0;
`endif

    assign status = {period_status, ch_status};
    assign irq    = |(status & irq_enable);

endmodule
